// File: rtl/pipe_stage_pkg.sv
// Shared definitions for pipeline stage registers: ID/EX field widths,
// bit offsets and packed views of the control and payload fields.
// The optional skid buffer is enabled by defining PIPE_STAGE_SKID_EN.
package pipe_stage_pkg;

   // ID/EX widths; other stages override CTRL_W/DATA_W on instantiation
   localparam int ID_EX_CTRL_W = 11;
   localparam int ID_EX_DATA_W = 245;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;
   // Upper payload bits left free for stage-specific extensions
   localparam int SPARE_W   = ID_EX_DATA_W - (6*XLEN - XLEN) - 3*REG_IDX_W;

   // Control bit offsets (LSB of each field)
   localparam int CTRL_ALUSRC_LSB     = 0;
   localparam int CTRL_ALUCONTROL_LSB = 1;
   localparam int CTRL_BRANCH_LSB     = 4;
   localparam int CTRL_JUMP_LSB       = 5;
   localparam int CTRL_MEMWRITE_LSB   = 6;
   localparam int CTRL_RESULTSRC_LSB  = 7;
   localparam int CTRL_REGWRITE_LSB   = 9;
   localparam int CTRL_SPARE_LSB      = 10;

   // Payload bit offsets (LSB of each field)
   localparam int DATA_PCPLUS4_LSB = 0;
   localparam int DATA_IMMEXT_LSB  = 32;
   localparam int DATA_RD_LSB      = 64;
   localparam int DATA_RS2_LSB     = 69;
   localparam int DATA_RS1_LSB     = 74;
   localparam int DATA_PC_LSB      = 79;
   localparam int DATA_RD2_LSB     = 111;
   localparam int DATA_RD1_LSB     = 143;
   localparam int DATA_SPARE_LSB   = 175;

   typedef struct packed {
      logic       spare;
      logic       RegWrite;
      logic [1:0] ResultSrc;
      logic       MemWrite;
      logic       Jump;
      logic       Branch;
      logic [2:0] ALUControl;
      logic       ALUSrc;
   } id_ex_ctrl_t;

   typedef struct packed {
      logic [SPARE_W-1:0]   spare;
      logic [XLEN-1:0]      rd1;
      logic [XLEN-1:0]      rd2;
      logic [XLEN-1:0]      PC;
      logic [REG_IDX_W-1:0] Rs1;
      logic [REG_IDX_W-1:0] Rs2;
      logic [REG_IDX_W-1:0] Rd;
      logic [XLEN-1:0]      ImmExt;
      logic [XLEN-1:0]      PCPlus4;
   } id_ex_data_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer holding the younger instruction while the output
// register is blocked. Control is zeroed whenever the entry is empty.
module pipe_skid_buf
   import pipe_stage_pkg::*;
#(
   parameter int CTRL_W = ID_EX_CTRL_W,
   parameter int DATA_W = ID_EX_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              load,
   input  logic              pop,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   // Entry state: reset > flush > pop > load
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (pop) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= in_ctrl;
         data  <= in_data;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB via
// CTRL_W/DATA_W). Bubbles always carry all-zero control so they can never
// write the regfile or memory. Define PIPE_STAGE_SKID_EN to add a one-entry
// skid buffer that removes the out_ready -> in_ready combinational path.
module pipe_stage_reg
   import pipe_stage_pkg::*;
#(
   parameter int CTRL_W = ID_EX_CTRL_W,
   parameter int DATA_W = ID_EX_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
);

   logic xfer_in;
   logic xfer_out;

   assign xfer_in  = in_valid & in_ready;
   assign xfer_out = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_valid;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic              skid_load;
   logic              skid_pop;

   // Ready depends only on local state, never on out_ready
   assign in_ready  = reset_n & ~stall & ~flush & ~skid_valid;
   // Younger entry parks in the skid only when the output is occupied and held
   assign skid_load = xfer_in & out_valid & ~out_ready;
   // Skid entry implies a valid output entry, so out_ready alone means drain
   assign skid_pop  = ~flush & ~stall & skid_valid & out_ready;

   pipe_skid_buf #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
   ) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .load    (skid_load),
      .pop     (skid_pop),
      .in_ctrl (in_ctrl),
      .in_data (in_data),
      .valid   (skid_valid),
      .ctrl    (skid_ctrl),
      .data    (skid_data)
   );

   // Output register: reset > flush > stall > skid refill > capture > drain
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         out_data  <= in_data;
      end else if (stall) begin
         out_valid <= out_valid;
      end else if (skid_pop) begin
         out_valid <= 1'b1;
         out_ctrl  <= skid_ctrl;
         out_data  <= skid_data;
      end else if (xfer_in && (!out_valid || out_ready)) begin
         out_valid <= 1'b1;
         out_ctrl  <= in_ctrl;
         out_data  <= in_data;
      end else if (xfer_out) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
      end
   end
`else
   assign in_ready = reset_n & ~stall & ~flush & (~out_valid | out_ready);

   // Output register: reset > flush > stall > capture > drain
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         out_data  <= in_data;
      end else if (stall) begin
         out_valid <= out_valid;
      end else if (xfer_in) begin
         out_valid <= 1'b1;
         out_ctrl  <= in_ctrl;
         out_data  <= in_data;
      end else if (xfer_out) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + random bench for pipe_stage_reg with an in-order scoreboard of
// entries held by the stage (output register, plus skid when
// PIPE_STAGE_SKID_EN is defined).
module tb_pipe_stage_reg;
   import pipe_stage_pkg::*;

   localparam int CW = ID_EX_CTRL_W;
   localparam int DW = ID_EX_DATA_W;
`ifdef PIPE_STAGE_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic          clk;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          stall;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;

   pipe_stage_reg dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .stall     (stall),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          sb[$];
   logic [DW-1:0] bub_data;
   bit            known;
   int            checks;
   int            failures;

   function automatic logic [DW-1:0] rnd();
      logic [255:0] t;
      t = {$urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom};
      return t[DW-1:0];
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, check outputs against the scoreboard, advance the model
   task automatic step(input string tag, input logic rn, input logic st, input logic fl,
                       input logic ordy, input logic iv,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
      logic exp_rdy;
      ent_t e;
      reset_n = rn; stall = st; flush = fl; out_ready = ordy;
      in_valid = iv; in_ctrl = c; in_data = d;
      @(negedge clk);
      if (!rn || st || fl)
         exp_rdy = 1'b0;
      else if (DEPTH == 1)
         exp_rdy = (sb.size() == 0) || ordy;
      else
         exp_rdy = (sb.size() < 2);
      chk({tag, ".in_ready"}, 256'(in_ready), 256'(exp_rdy));
      if (known) begin
         chk({tag, ".out_valid"}, 256'(out_valid), 256'(sb.size() > 0));
         if (sb.size() > 0) begin
            chk({tag, ".out_ctrl"}, 256'(out_ctrl), 256'(sb[0].c));
            chk({tag, ".out_data"}, 256'(out_data), 256'(sb[0].d));
         end else begin
            chk({tag, ".out_ctrl_bubble"}, 256'(out_ctrl), 256'(0));
            chk({tag, ".out_data_bubble"}, 256'(out_data), 256'(bub_data));
         end
      end
      if (!rn) begin
         sb.delete();
         bub_data = '0;
         known = 1'b1;
      end else if (fl) begin
         sb.delete();
         bub_data = d;
      end else if (!st) begin
         if (sb.size() > 0 && ordy) begin
            e = sb.pop_front();
            bub_data = e.d;
         end
         if (iv && exp_rdy) sb.push_back(ent_t'{c: c, d: d});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0; failures = 0; known = 1'b0; bub_data = '0;
      reset_n = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_valid = 1'b0; in_ctrl = '0; in_data = '0;

      // Reset held two cycles with a valid all-ones control word offered
      step("rst0", 0, 0, 0, 0, 1, 'h7FF, rnd());
      step("rst1", 0, 0, 0, 0, 1, 'h7FF, rnd());
      step("rst_rel", 1, 0, 0, 1, 0, '0, '0);

      // Back-to-back stream
      for (int i = 0; i < 8; i++) step("stream", 1, 0, 0, 1, 1, CW'(i), rnd());
      step("stream_end", 1, 0, 0, 1, 0, '0, '0);

      // Stall with out_ready=1 holds the entry
      step("ld155", 1, 0, 0, 0, 1, 'h155, rnd());
      for (int i = 0; i < 3; i++) step("stall", 1, 1, 0, 1, 1, 'h0AA, rnd());
      step("stall_rel", 1, 0, 0, 1, 0, '0, '0);
      step("stall_idle", 1, 0, 0, 1, 0, '0, '0);

      // Flush passes payload into the bubble
      step("ld_fl", 1, 0, 0, 0, 1, 'h03C, rnd());
      step("flush", 1, 0, 1, 0, 1, 'h012, 'h1000);
      step("post_flush", 1, 0, 0, 0, 0, '0, '0);

      // Flush beats stall and input
      step("ld_fs", 1, 0, 0, 0, 1, 'h002, rnd());
      step("flush_stall", 1, 1, 1, 1, 1, 'h007, rnd());
      step("post_fs", 1, 0, 0, 0, 0, '0, '0);

      // Backpressure then in-order drain
      step("bp_a", 1, 0, 0, 0, 1, 'h0A1, rnd());
      step("bp_b", 1, 0, 0, 0, 1, 'h0B2, rnd());
      step("bp_c", 1, 0, 0, 0, 1, 'h0C3, rnd());
      step("bp_d1", 1, 0, 0, 1, 0, '0, '0);
      step("bp_d2", 1, 0, 0, 1, 0, '0, '0);
      step("bp_d3", 1, 0, 0, 1, 0, '0, '0);

      // Reset while stalled with held entries discards them
      step("rm_a", 1, 0, 0, 0, 1, 'h111, rnd());
      step("rm_b", 1, 0, 0, 0, 1, 'h222, rnd());
      step("rm_st", 1, 1, 0, 0, 1, 'h333, rnd());
      step("rm_rst", 0, 1, 0, 0, 1, 'h444, rnd());
      step("rm_rel", 1, 0, 0, 1, 0, '0, '0);

      // Random mix
      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom_range(0, 24) != 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), CW'($urandom), rnd());
      step("final", 1, 0, 0, 1, 0, '0, '0);
      step("final2", 1, 0, 0, 1, 0, '0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
